fpaddsub_norm_shift: RTL and testbench
======================================

Name: fpaddsub_norm_shift

Overview:
- Normalization shifter for the FP add/sub datapath; the left-shift counterpart of the alignment right-shifter.
- Takes the raw 26-bit mantissa sum (carry plus 25 bits) with its tentative exponent.
- Produces a mantissa with the leading one at bit 24, an adjusted exponent, and zero/under/overflow flags.
- Two-stage pipeline (coarse shift by multiples of 4, then fine shift of 0 to 3) with valid/ready flow control, feeding the rounding stage.

Parameters:
- MANT_W, 25, mantissa width incl. hidden bit and guard bits; sum width is MANT_W+1.
- EXP_W, 8, exponent width.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input beat
- in_sum  in  26  raw sum; bit 25 = carry out
- in_exp  in  8  tentative exponent (larger operand's)
- in_sign  in  1  result sign, passed through
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_mant  out  25  normalized mantissa, leading one at bit 24
- out_exp  out  8  adjusted exponent (0 on zero or underflow, 255 on overflow)
- out_sign  out  1  sign, delayed
- out_sticky  out  1  bit shifted out on carry right-shift
- out_zero  out  1  in_sum was zero
- out_uflow  out  1  adjusted exponent would be <= 0
- out_oflow  out  1  adjusted exponent would be >= 255

Behaviour:
- Reset and clocking:
  - Single clock clk; rst is synchronous and active-high.
  - While rst is high at a clk edge, all stage valids and every output register clear to 0. This includes out_valid, out_mant, out_exp, out_sign, out_sticky and all flags.
  - in_ready is 0 while rst is asserted.
  - A beat in flight when rst rises is discarded; there is no partial completion.
- Latency and flow control:
  - Latency is 2 cycles from input acceptance (in_valid & in_ready) to out_valid, with no stalls.
  - Throughput is 1 beat/cycle.
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, combinational from out_ready; no skid buffer.
  - A stage loads only when it advances. Stalled stage contents and outputs hold bit-stable.
  - out_valid must not drop without out_ready.
- Stage 1 (register on accept):
  - Carry case (in_sum[25]=1): m1 = in_sum[25:1], sticky = in_sum[0], fine = 0, e = in_exp + 1, computed 10-bit signed.
  - Non-carry case: lzc = leading zeros of in_sum[24:0], range 0..24, or 25 if zero.
    - m1 = in_sum[24:0] << (lzc & ~3)
    - fine = lzc[1:0]
    - e = in_exp - lzc
    - sticky = 0
  - Zero case: in_sum == 0 sets zero = 1, m1 = 0, e = 0.
- Stage 2 (register on advance):
  - out_mant = m1 << fine, zero-filled.
  - zero = 1: out_exp = 0, out_uflow = 0, out_oflow = 0.
  - e <= 0: out_uflow = 1, out_exp = 0; out_mant is still the shifted value.
  - e >= 255: out_oflow = 1, out_exp = 255.
  - Otherwise out_exp = e[7:0].
- Flag rules:
  - At most one of out_zero, out_uflow, out_oflow is set.
  - out_sticky is only ever set on carry beats.
- Coarse/fine split: shift amounts 0..24 map to coarse {0,4,...,24} plus fine {0..3}. Coarse 24 occurs only with fine 0.

Decomposition:
- Package fpaddsub_pkg holds:
  - MANT_W, EXP_W, SUM_W (= MANT_W+1)
  - EXP_MAX (255)
  - the signed intermediate exponent width (EXP_W+2)
  - a packed struct for the stage-1 payload: m1, fine, e, sign, sticky, zero
- One sub-module: fpaddsub_lzc25, a combinational 25-bit leading-zero counter. Output is 5 bits; all-zero input yields 25.

Test Plan:
- Carry: in_sum=0x3000000, in_exp=100 -> 2 cycles later out_mant=0x1800000, out_exp=101, out_sticky=0. Repeat with in_sum=0x3000001 -> out_sticky=1.
- Already normalized: in_sum=0x1000000, in_exp=127 -> out_mant=0x1000000, out_exp=127, all flags 0.
- Mixed shift: in_sum=0x0000080 (lzc=17: coarse 16, fine 1), in_exp=50 -> out_mant=0x1000000, out_exp=33.
- Zero and underflow:
  - in_sum=0 -> out_zero=1, out_mant=0, out_exp=0.
  - in_sum=0x0000001, in_exp=10 -> out_uflow=1, out_exp=0.
- Overflow: in_sum=0x2000000, in_exp=254 -> out_oflow=1, out_exp=255.
- Back-pressure and reset:
  - Stream 5 beats at 1/cycle with out_ready low for cycles 3-5. Check in_ready falls once both stages are full, outputs hold stable, and all 5 beats emerge in order with no loss or duplication.
  - Assert rst mid-stream: next cycle out_valid=0 and all outputs 0.

Source files
------------

// File: rtl/fpaddsub_pkg.sv
// Shared widths and the stage-1 payload for the FP add/sub normalization shifter.
package fpaddsub_pkg;

    localparam int unsigned MANT_W  = 25;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned SUM_W   = MANT_W + 1;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned EI_W    = EXP_W + 2;
    localparam int unsigned LZC_W   = 5;

    localparam logic signed [EI_W-1:0] EXP_MAX_S = EI_W'(EXP_MAX);

    typedef struct packed {
        logic [MANT_W-1:0]      m1;
        logic [1:0]             fine;
        logic signed [EI_W-1:0] e;
        logic                   sign;
        logic                   sticky;
        logic                   zero;
    } s1_t;

endpackage

// File: rtl/fpaddsub_lzc25.sv
// Combinational 25-bit leading-zero counter; an all-zero input reports 25.
module fpaddsub_lzc25
    import fpaddsub_pkg::*;
(
    input  logic [MANT_W-1:0] v,
    output logic [LZC_W-1:0]  cnt
);

    // Ascending scan so the most significant set bit wins.
    always_comb begin
        cnt = LZC_W'(MANT_W);
        for (int i = 0; i < int'(MANT_W); i++) begin
            if (v[i]) begin
                cnt = LZC_W'(int'(MANT_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpaddsub_norm_shift.sv
// Two-stage normalization shifter: coarse (multiple-of-4) shift with exponent adjust,
// then fine shift and exponent range classification, with valid/ready flow control.
module fpaddsub_norm_shift
    import fpaddsub_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  in_sum,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_sticky,
    output logic              out_zero,
    output logic              out_uflow,
    output logic              out_oflow
);

    logic             s1_valid;
    s1_t              s1;
    s1_t              s1_nxt;
    logic             s1_adv;
    logic             s2_adv;
    logic [LZC_W-1:0] lzc;

    logic signed [EI_W-1:0] e2;
    logic [MANT_W-1:0]      mant_nxt;
    logic [EXP_W-1:0]       exp_nxt;
    logic                   uflow_nxt;
    logic                   oflow_nxt;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !rst;

    fpaddsub_lzc25 u_lzc (
        .v   (in_sum[MANT_W-1:0]),
        .cnt (lzc)
    );

    // Stage 1: carry right-shift, or coarse left-shift by the lzc rounded down to 4.
    always_comb begin
        s1_nxt      = '0;
        s1_nxt.sign = in_sign;
        if (in_sum == '0) begin
            s1_nxt.zero = 1'b1;
        end else if (in_sum[SUM_W-1]) begin
            s1_nxt.m1     = in_sum[SUM_W-1:1];
            s1_nxt.sticky = in_sum[0];
            s1_nxt.e      = $signed({2'b00, in_exp}) + EI_W'(1);
        end else begin
            s1_nxt.m1   = in_sum[MANT_W-1:0] << {lzc[LZC_W-1:2], 2'b00};
            s1_nxt.fine = lzc[1:0];
            s1_nxt.e    = $signed({2'b00, in_exp}) - $signed({(EI_W-LZC_W)'(0), lzc});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= s1_nxt;
            end
        end
    end

    // Stage 2: fine shift and exponent range classification.
    assign e2 = s1.e;

    always_comb begin
        mant_nxt  = s1.m1 << s1.fine;
        exp_nxt   = '0;
        uflow_nxt = 1'b0;
        oflow_nxt = 1'b0;
        if (s1.zero) begin
            mant_nxt = '0;
        end else if (e2 <= $signed(EI_W'(0))) begin
            uflow_nxt = 1'b1;
        end else if (e2 >= EXP_MAX_S) begin
            oflow_nxt = 1'b1;
            exp_nxt   = EXP_W'(EXP_MAX);
        end else begin
            exp_nxt = e2[EXP_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_sign   <= 1'b0;
            out_sticky <= 1'b0;
            out_zero   <= 1'b0;
            out_uflow  <= 1'b0;
            out_oflow  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant   <= mant_nxt;
                out_exp    <= exp_nxt;
                out_sign   <= s1.sign;
                out_sticky <= s1.sticky;
                out_zero   <= s1.zero;
                out_uflow  <= uflow_nxt;
                out_oflow  <= oflow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fpaddsub_norm_shift.sv
// Scoreboard bench for fpaddsub_norm_shift: directed vectors, back-pressure, reset, random traffic.
module tb_fpaddsub_norm_shift;

    typedef logic [37:0] res_t; // {mant25, exp8, sign, sticky, zero, uflow, oflow}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] in_sum = '0;
    logic [7:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [24:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_sticky;
    logic        out_zero;
    logic        out_uflow;
    logic        out_oflow;

    int   n_vec = 0;
    int   n_err = 0;
    res_t expq[$];
    int   rdy_mode = 0;
    int   cyc = 0;
    int   bp_base = 0;
    bit   saw_stall = 1'b0;
    bit   held = 1'b0;
    res_t snap;

    fpaddsub_norm_shift dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_sign   (out_sign),
        .out_sticky (out_sticky),
        .out_zero   (out_zero),
        .out_uflow  (out_uflow),
        .out_oflow  (out_oflow)
    );

    always #5 clk = ~clk;

    function automatic res_t actual();
        return {out_mant, out_exp, out_sign, out_sticky, out_zero, out_uflow, out_oflow};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: find the leading one, shift it to bit 24, adjust the exponent by the distance.
    function automatic res_t model(input logic [25:0] s, input logic [7:0] ex, input logic sg);
        logic [24:0] mant = '0;
        logic [7:0]  eo = '0;
        logic        sticky = 1'b0, zero = 1'b0, uf = 1'b0, of = 1'b0;
        int          e = 0;
        int          p = 0;
        if (s == 26'd0) begin
            zero = 1'b1;
        end else begin
            if (s >= 26'h2000000) begin
                mant   = s[25:1];
                sticky = s[0];
                e      = int'(ex) + 1;
            end else begin
                for (int i = 0; i < 25; i++) if (s[i]) p = i;
                mant = 25'(s << (24 - p));
                e    = int'(ex) - (24 - p);
            end
            if (e <= 0) uf = 1'b1;
            else if (e >= 255) begin of = 1'b1; eo = 8'd255; end
            else eo = 8'(e);
        end
        return {mant, eo, sg, sticky, zero, uf, of};
    endfunction

    function automatic logic [25:0] rnd_sum();
        int          k;
        logic [25:0] s;
        k = $urandom_range(0, 26);
        if (k == 0) return 26'd0;
        s = 26'($urandom) & ((26'd1 << k) - 26'd1);
        s[k-1] = 1'b1;
        return s;
    endfunction

    // Downstream ready generator.
    always @(negedge clk) begin
        int rel;
        cyc++;
        rel = cyc - bp_base;
        case (rdy_mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = !(rel >= 4 && rel <= 6);
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: hold-stability while stalled, pop and compare on each transfer.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) check("hold", 64'({out_valid, actual()}), 64'({1'b1, snap}));
            if (out_valid && out_ready) begin
                held = 1'b0;
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL beat: unexpected output %h with empty scoreboard", actual());
                end else begin
                    check("beat", 64'(actual()), 64'(expq.pop_front()));
                end
            end else if (out_valid) begin
                snap = actual();
                held = 1'b1;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send(input logic [25:0] s, input logic [7:0] e, input logic sg);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        in_exp   = e;
        in_sign  = sg;
        #1;
        while (!in_ready && t < 100) begin
            saw_stall = 1'b1;
            @(negedge clk);
            #1;
            t++;
        end
        if (in_ready) begin
            expq.push_back(model(s, e, sg));
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept: in_ready stuck at %b, expected 1", in_ready);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        expq.delete();
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_outputs", 64'({out_valid, actual()}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        idle();
        rdy_mode = 0;
        while ((expq.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("init_in_ready", 64'(in_ready), 64'd0);
        check("init_outputs", 64'({out_valid, actual()}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        send(26'h3000000, 8'd100, 1'b0);
        send(26'h3000001, 8'd100, 1'b1);
        send(26'h1000000, 8'd127, 1'b0);
        send(26'h0000080, 8'd50,  1'b1);
        send(26'h0000000, 8'd77,  1'b0);
        send(26'h0000001, 8'd10,  1'b0);
        send(26'h2000000, 8'd254, 1'b1);
        send(26'h0F00000, 8'd0,   1'b0);
        send(26'h1FFFFFF, 8'd255, 1'b0);
        send(26'h3FFFFFF, 8'd253, 1'b1);
        drain();

        // Back-pressure: five beats back to back, downstream stalls for three cycles.
        @(negedge clk);
        #1;
        bp_base   = cyc;
        rdy_mode  = 2;
        saw_stall = 1'b0;
        for (int i = 0; i < 5; i++) send(rnd_sum(), 8'($urandom_range(0, 255)), 1'($urandom));
        drain();
        check("bp_in_ready_fell", 64'(saw_stall), 64'd1);

        // Random traffic with random back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(rnd_sum(), 8'($urandom_range(0, 255)), 1'($urandom));
        end

        // Reset while beats are in flight; they are discarded.
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) send(rnd_sum(), 8'($urandom_range(0, 255)), 1'($urandom));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
